pc_sequencer: RTL and testbench

Fetch-stage program-counter sequencer for the MIPS datapath. It holds the PC and issues fetch addresses to instruction memory over a valid/ready handshake. It consumes the word-aligned branch offset produced by `ShiftLeft2` and forms branch, jump and jump-register targets. Redirects that arrive while memory back-pressures are buffered, so the fetch address never changes under an outstanding request.

---
 rtl/mips_pkg.sv | 14 +
 rtl/pc_target_calc.sv | 37 +++
 rtl/pc_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch stage.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target formation: JR over J/JAL over taken branch, with word alignment forced.
module pc_target_calc
  import mips_pkg::*;
(
  input  logic [INSTR_W-1:0] i_pc_plus4,
  input  logic [INSTR_W-1:0] i_imm_shifted,
  input  logic [25:0]        i_jump_index,
  input  logic [INSTR_W-1:0] i_jr_target,
  input  logic               i_redirect_valid,
  input  logic               i_branch_taken,
  input  logic               i_jump,
  input  logic               i_jr,
  output logic [INSTR_W-1:0] o_target,
  output logic               o_misalign,
  output logic               o_any_redirect
);

  logic [INSTR_W-1:0] w_branch_target;

  // Branch adder; the carry out is intentionally dropped so targets wrap mod 2^32.
  assign w_branch_target = i_pc_plus4 + i_imm_shifted;

  // Priority target mux
  always_comb begin
    o_target = w_branch_target;
    if (i_jr) begin
      o_target = {i_jr_target[INSTR_W-1:2], 2'b00};
    end else if (i_jump) begin
      o_target = {i_pc_plus4[INSTR_W-1:28], i_jump_index, 2'b00};
    end
  end

  assign o_misalign     = i_redirect_valid & i_jr & (i_jr_target[1:0] != 2'b00);
  // A redirect strobe with no select raised carries no target and is ignored.
  assign o_any_redirect = i_redirect_valid & (i_jr | i_jump | i_branch_taken);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: issues fetch addresses over valid/ready and buffers one
// redirect that arrives while memory is stalling or the stage is halted.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halt,
  input  logic               resume,
  input  logic               redirect_valid,
  input  logic               branch_taken,
  input  logic [INSTR_W-1:0] imm_shifted,
  input  logic               jump,
  input  logic [25:0]        jump_index,
  input  logic               jr,
  input  logic [INSTR_W-1:0] jr_target,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [INSTR_W-1:0] pc,
  output logic [INSTR_W-1:0] pc_plus4,
  output logic [INSTR_W-1:0] fetch_count,
  output logic               addr_err
);

  pc_state_e          r_state;
  logic               r_req_valid;
  logic [INSTR_W-1:0] r_pc;
  logic               r_pend_valid;
  logic [INSTR_W-1:0] r_pend_pc;
  logic [INSTR_W-1:0] r_fetch_count;
  logic               r_addr_err;

  logic               w_accept;
  logic [INSTR_W-1:0] w_pc_plus4;
  logic [INSTR_W-1:0] w_target;
  logic               w_misalign;
  logic               w_any_redirect;
  logic [INSTR_W-1:0] w_next_pc;

  assign w_accept   = r_req_valid & req_ready;
  assign w_pc_plus4 = r_pc + PC_STEP;

  pc_target_calc u_target_calc (
    .i_pc_plus4      (w_pc_plus4),
    .i_imm_shifted   (imm_shifted),
    .i_jump_index    (jump_index),
    .i_jr_target     (jr_target),
    .i_redirect_valid(redirect_valid),
    .i_branch_taken  (branch_taken),
    .i_jump          (jump),
    .i_jr            (jr),
    .o_target        (w_target),
    .o_misalign      (w_misalign),
    .o_any_redirect  (w_any_redirect)
  );

  // Next fetch address on accept: a same-cycle redirect beats the buffered one.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (w_any_redirect) begin
      w_next_pc = w_target;
    end else if (r_pend_valid) begin
      w_next_pc = r_pend_pc;
    end
  end

  // Sequencer FSM; req_valid is registered alongside the state so it never sees req_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StBoot;
      r_req_valid <= 1'b0;
    end else begin
      case (r_state)
        StBoot: begin
          r_state     <= StRun;
          r_req_valid <= 1'b1;
        end
        StRun: begin
          // An issued request must complete before halting, so halt waits for accept.
          if (halt && w_accept) begin
            r_state     <= StHalt;
            r_req_valid <= 1'b0;
          end
        end
        StHalt: begin
          if (resume) begin
            r_state     <= StRun;
            r_req_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= StBoot;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  // PC register and single-entry redirect buffer; pc only moves on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= RESET_PC;
    end else if (w_accept) begin
      r_pc         <= w_next_pc;
      r_pend_valid <= 1'b0;
    end else if (w_any_redirect) begin
      r_pend_valid <= 1'b1;
      r_pend_pc    <= w_target;
    end
  end

  // Accepted-fetch counter and sticky misaligned-JR flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= '0;
      r_addr_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_misalign) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  assign req_valid   = r_req_valid;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign fetch_count = r_fetch_count;
  assign addr_err    = r_addr_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand sequences, random vs model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, halt, resume, redirect_valid, branch_taken, jump, jr, req_ready;
  logic [31:0] imm_shifted, jr_target;
  logic [25:0] jump_index;
  logic        req_valid, addr_err;
  logic [31:0] pc, pc_plus4, fetch_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .halt          (halt),
    .resume        (resume),
    .redirect_valid(redirect_valid),
    .branch_taken  (branch_taken),
    .imm_shifted   (imm_shifted),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .fetch_count   (fetch_count),
    .addr_err      (addr_err)
  );

  // Redirect kinds used by the vector table
  localparam int KNone = 0, KEmpty = 1, KBranch = 2, KJump = 3, KJr = 4;

  typedef struct {
    logic        rst, halt, resume, ready;
    int          kind;
    logic [31:0] val;
    logic        e_valid;
    logic [31:0] e_pc, e_cnt;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(logic r, logic h, logic rs, logic rdy, int k, logic [31:0] v,
                               logic ev, logic [31:0] ep, logic [31:0] ec, logic ee);
    vec_t x;
    x.rst = r; x.halt = h; x.resume = rs; x.ready = rdy; x.kind = k; x.val = v;
    x.e_valid = ev; x.e_pc = ep; x.e_cnt = ec; x.e_err = ee;
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic drive(logic r, logic h, logic rs, logic rdy, int k, logic [31:0] v);
    @(negedge clk);
    rst = r; halt = h; resume = rs; req_ready = rdy;
    redirect_valid = (k != KNone);
    branch_taken   = (k == KBranch);
    jump           = (k == KJump);
    jr             = (k == KJr);
    imm_shifted    = (k == KBranch) ? v : 32'h0;
    jump_index     = (k == KJump) ? v[25:0] : 26'h0;
    jr_target      = (k == KJr) ? v : 32'h0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(string tag, logic ev, logic [31:0] ep, logic [31:0] ec, logic ee);
    chk({tag, ".valid"}, {31'd0, req_valid}, {31'd0, ev});
    chk({tag, ".pc"}, pc, ep);
    chk({tag, ".pc_plus4"}, pc_plus4, ep + 32'd4);
    chk({tag, ".count"}, fetch_count, ec);
    chk({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, ee});
  endtask

  // Reference model state (abstract: halted/booting flags, optional pending target)
  logic [31:0] m_pc, m_cnt, m_pend_pc;
  logic        m_err, m_pend, m_booting, m_halted;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; halt = 0; resume = 0; redirect_valid = 0; branch_taken = 0; jump = 0;
    jr = 0; req_ready = 0; imm_shifted = 0; jr_target = 0; jump_index = 0;

    //                 rst h rs rdy kind     val             ev  pc             cnt  err
    tbl.push_back(row(1, 0, 0, 1, KNone,   32'h0,          0, 32'h0,         0,  0));
    tbl.push_back(row(1, 0, 0, 1, KNone,   32'h0,          0, 32'h0,         0,  0));
    tbl.push_back(row(0, 0, 0, 1, KNone,   32'h0,          1, 32'h0,         0,  0));
    tbl.push_back(row(0, 0, 0, 1, KNone,   32'h0,          1, 32'h4,         1,  0));
    tbl.push_back(row(0, 0, 0, 1, KNone,   32'h0,          1, 32'h8,         2,  0));
    tbl.push_back(row(0, 0, 0, 1, KNone,   32'h0,          1, 32'hC,         3,  0));
    tbl.push_back(row(0, 0, 0, 1, KNone,   32'h0,          1, 32'h10,        4,  0));
    tbl.push_back(row(0, 0, 0, 1, KBranch, 32'hFFFF_FFF0,  1, 32'h4,         5,  0));
    tbl.push_back(row(0, 0, 0, 1, KJr,     32'hFFFF_FFFC,  1, 32'hFFFF_FFFC, 6,  0));
    tbl.push_back(row(0, 0, 0, 1, KBranch, 32'h8,          1, 32'h8,         7,  0));
    tbl.push_back(row(0, 0, 0, 1, KJr,     32'h1000_0008,  1, 32'h1000_0008, 8,  0));
    tbl.push_back(row(0, 0, 0, 1, KJump,   32'h40,         1, 32'h1000_0100, 9,  0));
    tbl.push_back(row(0, 0, 0, 1, KJr,     32'h20,         1, 32'h20,        10, 0));
    tbl.push_back(row(0, 0, 0, 0, KJr,     32'h200,        1, 32'h20,        10, 0));
    tbl.push_back(row(0, 0, 0, 0, KBranch, 32'h10,         1, 32'h20,        10, 0));
    tbl.push_back(row(0, 0, 0, 0, KNone,   32'h0,          1, 32'h20,        10, 0));
    tbl.push_back(row(0, 0, 0, 1, KNone,   32'h0,          1, 32'h34,        11, 0));
    tbl.push_back(row(0, 0, 0, 1, KJr,     32'h203,        1, 32'h200,       12, 1));
    tbl.push_back(row(0, 0, 0, 1, KNone,   32'h0,          1, 32'h204,       13, 1));
    tbl.push_back(row(0, 0, 0, 0, KJr,     32'h500,        1, 32'h204,       13, 1));
    tbl.push_back(row(1, 0, 0, 1, KJr,     32'h900,        0, 32'h0,         0,  0));
    tbl.push_back(row(0, 0, 0, 0, KNone,   32'h0,          1, 32'h0,         0,  0));
    tbl.push_back(row(0, 0, 0, 1, KNone,   32'h0,          1, 32'h4,         1,  0));
    tbl.push_back(row(0, 1, 0, 1, KNone,   32'h0,          0, 32'h8,         2,  0));
    tbl.push_back(row(0, 1, 0, 1, KNone,   32'h0,          0, 32'h8,         2,  0));
    tbl.push_back(row(0, 0, 0, 1, KJump,   32'h100,        0, 32'h8,         2,  0));
    tbl.push_back(row(0, 1, 1, 1, KNone,   32'h0,          1, 32'h8,         2,  0));
    tbl.push_back(row(0, 0, 0, 1, KNone,   32'h0,          1, 32'h400,       3,  0));
    tbl.push_back(row(0, 0, 0, 1, KEmpty,  32'h0,          1, 32'h404,       4,  0));
    tbl.push_back(row(0, 1, 0, 0, KNone,   32'h0,          1, 32'h404,       4,  0));
    tbl.push_back(row(0, 1, 0, 1, KNone,   32'h0,          0, 32'h408,       5,  0));
    tbl.push_back(row(0, 0, 1, 0, KNone,   32'h0,          1, 32'h408,       5,  0));
    tbl.push_back(row(0, 0, 0, 1, KNone,   32'h0,          1, 32'h40C,       6,  0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].halt, tbl[i].resume, tbl[i].ready, tbl[i].kind, tbl[i].val);
      chk_all($sformatf("row%0d", i), tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_cnt, tbl[i].e_err);
    end

    // Sticky addr_err survives unrelated traffic and only reset clears it.
    drive(0, 0, 0, 1, KJr, 32'h203);
    chk_all("misjr", 1, 32'h200, 7, 1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 1'($urandom_range(0, 1)), KNone, 32'h0);
      chk($sformatf("sticky%0d", i), {31'd0, addr_err}, 32'd1);
    end
    drive(1, 0, 0, 1, KNone, 32'h0);
    chk_all("rst_clr", 0, 32'h0, 0, 0);

    // Same-cycle redirect overrides a buffered one, and the buffer is then consumed.
    drive(0, 0, 0, 0, KNone, 32'h0);
    drive(0, 0, 0, 0, KJr, 32'h100);
    chk_all("pend_hold", 1, 32'h0, 0, 0);
    drive(0, 0, 0, 1, KBranch, 32'h20);
    chk_all("same_wins", 1, 32'h24, 1, 0);
    drive(0, 0, 0, 1, KNone, 32'h0);
    chk_all("pend_gone", 1, 32'h28, 2, 0);

    // Randomized phase against the behavioural model; start from a reset.
    drive(1, 0, 0, 0, KNone, 32'h0);
    m_pc = 32'h0; m_cnt = 0; m_err = 0; m_pend = 0; m_pend_pc = 0;
    m_booting = 1; m_halted = 0;
    for (int c = 0; c < 1500; c++) begin
      logic        r_rst, r_acc, r_has;
      logic [31:0] tgt;
      @(negedge clk);
      r_rst          = ($urandom_range(0, 59) == 0);
      rst            = r_rst;
      halt           = ($urandom_range(0, 7) == 0);
      resume         = ($urandom_range(0, 5) == 0);
      req_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 2) == 0);
      branch_taken   = 1'($urandom_range(0, 1));
      jump           = ($urandom_range(0, 3) == 0);
      jr             = ($urandom_range(0, 3) == 0);
      imm_shifted    = {{14{1'($urandom_range(0, 1))}}, 18'($urandom)} & 32'hFFFF_FFFC;
      jump_index     = 26'($urandom);
      jr_target      = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);

      if (r_rst) begin
        m_pc = 32'h0; m_cnt = 0; m_err = 0; m_pend = 0; m_booting = 1; m_halted = 0;
      end else begin
        r_acc = !m_booting && !m_halted && req_ready;
        r_has = redirect_valid && (jr || jump || branch_taken);
        if (jr)        tgt = jr_target & ~32'd3;
        else if (jump) tgt = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, jump_index} * 32'd4);
        else           tgt = m_pc + 32'd4 + imm_shifted;
        if (redirect_valid && jr && (jr_target % 4 != 0)) m_err = 1;
        if (r_acc) begin
          m_pc   = r_has ? tgt : (m_pend ? m_pend_pc : m_pc + 32'd4);
          m_pend = 0;
          m_cnt  = m_cnt + 1;
        end else if (r_has) begin
          m_pend    = 1;
          m_pend_pc = tgt;
        end
        if (m_booting)                     m_booting = 0;
        else if (m_halted && resume)       m_halted = 0;
        else if (!m_halted && halt && r_acc) m_halted = 1;
      end
      @(posedge clk);
      #1;
      chk_all($sformatf("rnd%0d", c), !m_booting && !m_halted, m_pc, m_cnt, m_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
